inst_fetch_axi: RTL and testbench
=================================

Name: inst_fetch_axi

Overview:
- AXI-Lite read initiator on the CPU instruction side; the requesting end of the instruction-memory interface.
- Takes a fetch address from the pipeline's PC stage and issues a single-beat AXI-Lite read on AR/R.
- Returns the 32-bit instruction word, stalls the pipeline while a read is outstanding, and discards in-flight reads on flush.
- The instruction ROM sits behind an AXI-Lite responder on the other side.

Parameters:
- ADDR_WIDTH, 32, width of pc and araddr.
- DATA_WIDTH, 32, width of inst and rdata; only 32 is supported.
- ARPROT_VAL, 3'b100, constant driven on arprot (instruction, secure, unprivileged).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  pipeline requests a fetch of pc; held high until inst_valid.
- pc  input  ADDR_WIDTH  fetch address; stable while fetch_req is high.
- flush  input  1  abandon the current fetch (branch/exception redirect).
- inst  output  DATA_WIDTH  fetched instruction; held until the next inst_valid.
- inst_valid  output  1  one-cycle pulse: inst holds the word for the accepted pc.
- stall_req  output  1  high while a fetch is pending and not yet delivered.
- bus_err  output  1  one-cycle pulse with inst_valid when rresp != OKAY.
- araddr  output  ADDR_WIDTH  AXI read address.
- arprot  output  3  constant ARPROT_VAL.
- arvalid  output  1  AXI read address valid.
- arready  input  1  AXI read address ready.
- rdata  input  DATA_WIDTH  AXI read data.
- rresp  input  2  AXI read response.
- rvalid  input  1  AXI read data valid.
- rready  output  1  AXI read data ready.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - arvalid=0, rready=0, araddr=0, inst=0, inst_valid=0, bus_err=0.
  - Reset mid-transaction abandons it; the AXI interconnect is reset by the same rst_n.
- FSM states: IDLE, ADDR, DATA, DISCARD.
- IDLE:
  - fetch_req=1 and flush=0 → latch pc into araddr, arvalid=1, go to ADDR.
  - inst_valid is never reasserted for the same request.
- ADDR:
  - arvalid stays high and araddr stays stable until arready=1 (AXI rule).
  - On handshake: arvalid=0 and rready=1 next cycle, go to DATA.
  - flush in ADDR: arvalid is still held until arready, then go to DISCARD, never to IDLE directly.
- DATA:
  - rready=1.
  - On rvalid: register rdata into inst, pulse inst_valid for one cycle, go to IDLE.
  - If rresp != 2'b00: inst=32'h0000_0000 (NOP) and bus_err pulses with inst_valid.
  - flush in DATA without rvalid: go to DISCARD.
  - flush in the same cycle as rvalid: data dropped, no inst_valid, go to IDLE.
- DISCARD:
  - rready=1 once the address phase completes.
  - On rvalid: drop data, no inst_valid, no bus_err, go to IDLE.
- stall_req:
  - Combinational: (fetch_req & ~inst_valid & ~flush) | (state != IDLE).
  - Stays high through DISCARD so the redirected pc is not fetched until the bus is idle.
- Latency:
  - Requests are accepted only in IDLE; one outstanding read maximum.
  - With arready and rvalid at their earliest: req in cycle 0, arvalid in cycle 1, R handshake in cycle 2, inst_valid in cycle 3.
- The address is issued unaligned-agnostic unless the optional feature is enabled.
- Back-to-back fetches: the next request is accepted in the cycle after inst_valid (IDLE).

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, fetch_req with pc[1:0] != 0 issues no AXI read.
  - Next cycle: inst=0, inst_valid=1, bus_err=1 (misaligned fetch reported via bus_err).
- Undefined: pc[1:0] passed through on araddr unchanged; no check logic.

Test Plan:
- Basic fetch: pc=32'h0000_0010, arready=1, rvalid one cycle after AR, rdata=32'h3C01_1234, rresp=0 → arvalid in cycle 1, inst=32'h3C01_1234 with inst_valid pulse in cycle 3, stall_req low from cycle 3.
- AR backpressure: arready low 4 cycles → arvalid and araddr=32'h0000_0010 held stable throughout; single AR handshake; inst_valid exactly once.
- Flush in DATA: flush pulsed one cycle after AR handshake, rvalid 3 cycles later with rdata=32'hDEAD_BEEF → no inst_valid, return to IDLE; new pc=32'h0000_0100 then fetched normally.
- Error response: rresp=2'b10, rdata=32'hFFFF_FFFF → inst=0, inst_valid=1 and bus_err=1 same cycle.
- Reset mid-read: rst_n low while in ADDR with arvalid=1 → arvalid, rready, inst_valid drop immediately (asynchronously); after release, state IDLE and no spurious inst_valid.
- FETCH_ALIGN_CHECK_EN: pc=32'h0000_0006 → arvalid never asserted; inst_valid=1, bus_err=1, inst=0 one cycle after request.

Source files
------------

// File: rtl/inst_fetch_axi.sv
// rtl/inst_fetch_axi.sv - AXI-Lite read initiator for instruction fetch (optional: FETCH_ALIGN_CHECK_EN)
module inst_fetch_axi #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  ARPROT_VAL = 3'b100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  stall_req,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_DATA    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // A flush seen while the address is still waiting for arready; the
  // read must still complete on the bus, so its data is later dropped.
  logic flush_pend;
  logic accept;
  logic misaligned;
  logic drop_addr;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // The cycle carrying inst_valid still sees the same fetch_req, so it is
  // not taken as a new request; the next request lands one cycle later.
  assign accept    = (state == S_IDLE) & fetch_req & ~flush & ~inst_valid;
  assign drop_addr = flush | flush_pend;
  assign arprot    = ARPROT_VAL;
  assign stall_req = (fetch_req & ~inst_valid & ~flush) | (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && !misaligned) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) begin
          state_nxt = drop_addr ? S_DISCARD : S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid) begin
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (rvalid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // AXI handshake outputs decoded from state
  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state)
      S_ADDR:    arvalid = 1'b1;
      S_DATA:    rready  = 1'b1;
      S_DISCARD: rready  = 1'b1;
      default: begin
        arvalid = 1'b0;
        rready  = 1'b0;
      end
    endcase
  end

  // Pending-flush flag, only meaningful while the address phase is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (state == S_ADDR) begin
      if (arready) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end else begin
      flush_pend <= 1'b0;
    end
  end

  // Address latch: captured once on acceptance, stable through ADDR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr <= '0;
    end else if (accept && !misaligned) begin
      araddr <= pc;
    end
  end

  // Instruction delivery: inst is held between pulses, errors deliver a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      bus_err    <= 1'b0;
      if (accept && misaligned) begin
        inst       <= '0;
        inst_valid <= 1'b1;
        bus_err    <= 1'b1;
      end else if (state == S_DATA && rvalid && !flush) begin
        inst_valid <= 1'b1;
        if (rresp == 2'b00) begin
          inst <= rdata;
        end else begin
          inst    <= '0;
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// tb/tb_inst_fetch_axi.sv - directed scoreboard bench for inst_fetch_axi
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall_req;
  logic        bus_err;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ar  = 0;
  int   n_iv  = 0;
  int   ar0;
  int   iv0;

  inst_fetch_axi #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ARPROT_VAL(3'b100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .pc        (pc),
    .flush     (flush),
    .inst      (inst),
    .inst_valid(inst_valid),
    .stall_req (stall_req),
    .bus_err   (bus_err),
    .araddr    (araddr),
    .arprot    (arprot),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 clk = ~clk;

  // Bus-level counters: AR handshakes and delivered instructions
  always @(posedge clk) begin
    if (arvalid && arready) n_ar = n_ar + 1;
    if (inst_valid) n_iv = n_iv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_inst"}, inst, e.word);
      chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, e.err});
    end
  endtask

  task automatic wait_inst(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (inst_valid !== 1'b1 && cyc < 20);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd1);
    if (inst_valid === 1'b1) pop_check(tag);
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; pc = '0; flush = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("arprot", {29'd0, arprot}, 32'd4);
    rst_n = 1'b1;

    // Basic fetch with earliest handshakes
    @(negedge clk);
    fetch_req = 1'b1; pc = 32'h0000_0010; arready = 1'b1;
    exp_q.push_back({32'h3C01_1234, 1'b0});
    #1 chk("basic_stall_c0", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    chk("basic_arvalid_c1", {31'd0, arvalid}, 32'd1);
    chk("basic_araddr_c1", araddr, 32'h0000_0010);
    @(negedge clk);
    chk("basic_arvalid_c2", {31'd0, arvalid}, 32'd0);
    chk("basic_rready_c2", {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata = 32'h3C01_1234; rresp = 2'b00;
    @(negedge clk);
    chk("basic_inst_valid_c3", {31'd0, inst_valid}, 32'd1);
    chk("basic_stall_c3", {31'd0, stall_req}, 32'd0);
    pop_check("basic");
    rvalid = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("basic_pulse_end", {31'd0, inst_valid}, 32'd0);
    chk("basic_inst_held", inst, 32'h3C01_1234);

    // AR backpressure for four cycles
    ar0 = n_ar; iv0 = n_iv;
    arready = 1'b0; fetch_req = 1'b1; pc = 32'h0000_0010;
    exp_q.push_back({32'h1111_2222, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_arvalid", {31'd0, arvalid}, 32'd1);
      chk("bp_araddr", araddr, 32'h0000_0010);
      chk("bp_stall", {31'd0, stall_req}, 32'd1);
    end
    arready = 1'b1;
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    wait_inst("bp");
    rvalid = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("bp_ar_count", n_ar - ar0, 32'd1);
    chk("bp_iv_count", n_iv - iv0, 32'd1);

    // Flush in DATA, then a redirected fetch
    iv0 = n_iv;
    fetch_req = 1'b1; pc = 32'h0000_0020;
    @(negedge clk);
    chk("fd_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fd_discard_rready", {31'd0, rready}, 32'd1);
    #1 chk("fd_discard_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0;
    chk("fd_no_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("fd_no_bus_err", {31'd0, bus_err}, 32'd0);
    chk("fd_idle_rready", {31'd0, rready}, 32'd0);
    chk("fd_inst_held", inst, 32'h1111_2222);
    #1 chk("fd_idle_stall", {31'd0, stall_req}, 32'd0);
    fetch_req = 1'b1; pc = 32'h0000_0100;
    exp_q.push_back({32'h0040_0093, 1'b0});
    @(negedge clk);
    chk("fd_new_araddr", araddr, 32'h0000_0100);
    chk("fd_new_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h0040_0093;
    wait_inst("fd_new");
    rvalid = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("fd_iv_count", n_iv - iv0, 32'd1);

    // Error response delivers NOP with bus_err
    fetch_req = 1'b1; pc = 32'h0000_0030;
    exp_q.push_back({32'h0000_0000, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b10;
    wait_inst("err");
    rvalid = 1'b0; rresp = 2'b00; fetch_req = 1'b0;
    @(negedge clk);
    chk("err_pulse_end", {31'd0, bus_err}, 32'd0);

    // Flush during ADDR: address still completes, data dropped
    iv0 = n_iv;
    arready = 1'b0; fetch_req = 1'b1; pc = 32'h0000_0040;
    @(negedge clk);
    flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fa_arvalid_held", {31'd0, arvalid}, 32'd1);
    chk("fa_araddr_held", araddr, 32'h0000_0040);
    @(negedge clk);
    chk("fa_arvalid_held2", {31'd0, arvalid}, 32'd1);
    arready = 1'b1;
    @(negedge clk);
    chk("fa_discard_arvalid", {31'd0, arvalid}, 32'd0);
    chk("fa_discard_rready", {31'd0, rready}, 32'd1);
    #1 chk("fa_discard_stall", {31'd0, stall_req}, 32'd1);
    rvalid = 1'b1; rdata = 32'h5555_5555;
    @(negedge clk);
    rvalid = 1'b0;
    chk("fa_no_inst_valid", {31'd0, inst_valid}, 32'd0);
    #1 chk("fa_idle_stall", {31'd0, stall_req}, 32'd0);
    chk("fa_iv_count", n_iv - iv0, 32'd0);

    // Flush coincident with rvalid
    fetch_req = 1'b1; pc = 32'h0000_0044;
    @(negedge clk);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h6666_6666; flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    rvalid = 1'b0; flush = 1'b0;
    chk("fr_no_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("fr_idle_rready", {31'd0, rready}, 32'd0);
    chk("fr_inst_held", inst, 32'h0000_0000);
    #1 chk("fr_idle_stall", {31'd0, stall_req}, 32'd0);

    // Unaligned pc
`ifdef FETCH_ALIGN_CHECK_EN
    ar0 = n_ar;
    fetch_req = 1'b1; pc = 32'h0000_0006;
    exp_q.push_back({32'h0000_0000, 1'b1});
    @(negedge clk);
    chk("ua_no_arvalid", {31'd0, arvalid}, 32'd0);
    chk("ua_inst_valid", {31'd0, inst_valid}, 32'd1);
    pop_check("ua");
    fetch_req = 1'b0;
    @(negedge clk);
    chk("ua_no_ar", n_ar - ar0, 32'd0);
    chk("ua_pulse_end", {31'd0, inst_valid}, 32'd0);
`else
    fetch_req = 1'b1; pc = 32'h0000_0006;
    exp_q.push_back({32'h7777_7777, 1'b0});
    @(negedge clk);
    chk("ua_araddr", araddr, 32'h0000_0006);
    chk("ua_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h7777_7777;
    wait_inst("ua");
    rvalid = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
`endif

    // Asynchronous reset during ADDR
    arready = 1'b0; fetch_req = 1'b1; pc = 32'h0000_0050;
    @(negedge clk);
    chk("rm_arvalid_pre", {31'd0, arvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_arvalid_async", {31'd0, arvalid}, 32'd0);
    chk("rm_rready_async", {31'd0, rready}, 32'd0);
    chk("rm_inst_valid_async", {31'd0, inst_valid}, 32'd0);
    chk("rm_araddr_async", araddr, 32'd0);
    fetch_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    iv0 = n_iv;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rm_no_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rm_idle_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rm_idle_stall", {31'd0, stall_req}, 32'd0);
    end
    chk("rm_iv_count", n_iv - iv0, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
